alu_4bit: RTL and testbench

//  4-bit ALU for the small accumulator CPU datapath. Operands are the accumulator

---
 rtl/alu_4bit.sv | 93 +++++++++
 tb/tb_alu_4bit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/alu_4bit.sv
// 4-bit accumulator-datapath ALU: one shared ripple adder serves add, subtract,
// multiply-step and divide-step; the sign/carry/zero flags are registered.
module alu_4bit (
    input  logic       alu_sub,
    input  logic       alu_div,
    input  logic [3:0] AH_in,
    input  logic [3:0] BREG_in,
    input  logic       alu_and,
    output logic [3:0] ALU_out,
    output logic       Fa_cout,
    input  logic       clk,
    input  logic       clr,
    input  logic       alu_add,
    input  logic       alu_mul,
    input  logic       al_lsb,
    output logic       sign_flag,
    output logic       carry_flag,
    output logic       zero_flag
);

    logic       sel_add;
    logic       sel_sub;
    logic       sel_mul;
    logic       sel_div;
    logic       sel_and;
    logic       any_sel;
    logic       inv;
    logic [3:0] b_eff;
    logic [3:0] sum;
    logic       sum_cout;

    logic       sign_reg;
    logic       carry_reg;
    logic       zero_reg;

    // One-hot decode so only the highest-priority select drives the result.
    assign sel_add = alu_add;
    assign sel_sub = ~alu_add & alu_sub;
    assign sel_mul = ~alu_add & ~alu_sub & alu_mul;
    assign sel_div = ~alu_add & ~alu_sub & ~alu_mul & alu_div;
    assign sel_and = ~alu_add & ~alu_sub & ~alu_mul & ~alu_div & alu_and;
    assign any_sel = alu_add | alu_sub | alu_mul | alu_div | alu_and;

    assign inv   = sel_sub | sel_div;
    assign b_eff = BREG_in ^ {4{inv}};

    // Ripple adder; for subtraction the carry-out is the "no borrow" indicator.
    always_comb begin
        logic c;
        sum = 4'b0000;
        c   = inv;
        for (int i = 0; i < 4; i++) begin
            sum[i] = AH_in[i] ^ b_eff[i] ^ c;
            c      = (AH_in[i] & b_eff[i]) | (c & (AH_in[i] ^ b_eff[i]));
        end
        sum_cout = c;
    end

    always_comb begin
        ALU_out = 4'b0000;
        Fa_cout = 1'b0;
        if (sel_add || sel_sub) begin
            ALU_out = sum;
            Fa_cout = sum_cout;
        end else if (sel_mul) begin
            ALU_out = al_lsb ? sum : AH_in;
            Fa_cout = al_lsb ? sum_cout : 1'b0;
        end else if (sel_div) begin
            // Restoring step: keep A when the trial subtraction borrows.
            ALU_out = sum_cout ? sum : AH_in;
            Fa_cout = sum_cout;
        end else if (sel_and) begin
            ALU_out = AH_in & BREG_in;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sign_reg  <= 1'b0;
            carry_reg <= 1'b0;
            zero_reg  <= 1'b0;
        end else if (any_sel) begin
            sign_reg  <= ALU_out[3];
            carry_reg <= Fa_cout;
            zero_reg  <= ~|ALU_out;
        end
    end

    assign sign_flag  = sign_reg;
    assign carry_flag = carry_reg;
    assign zero_flag  = zero_reg;

endmodule

// File: tb/tb_alu_4bit.sv
// Bench for alu_4bit: directed cases followed by random operations, each checked
// against an arithmetic reference model of results and flags.
module tb_alu_4bit;

    logic       clk;
    logic       clr;
    logic       alu_sub;
    logic       alu_div;
    logic       alu_and;
    logic       alu_add;
    logic       alu_mul;
    logic       al_lsb;
    logic [3:0] AH_in;
    logic [3:0] BREG_in;
    logic [3:0] ALU_out;
    logic       Fa_cout;
    logic       sign_flag;
    logic       carry_flag;
    logic       zero_flag;

    int assert_cnt;
    int fail_cnt;

    // Reference flag state, valid once the first clr transaction has run.
    logic m_sign;
    logic m_carry;
    logic m_zero;

    alu_4bit dut (
        .alu_sub    (alu_sub),
        .alu_div    (alu_div),
        .AH_in      (AH_in),
        .BREG_in    (BREG_in),
        .alu_and    (alu_and),
        .ALU_out    (ALU_out),
        .Fa_cout    (Fa_cout),
        .clk        (clk),
        .clr        (clr),
        .alu_add    (alu_add),
        .alu_mul    (alu_mul),
        .al_lsb     (al_lsb),
        .sign_flag  (sign_flag),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        assert_cnt++;
        if (observed !== expected) begin
            fail_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: sel = {add, sub, mul, div, and}; priority add > sub > mul > div > and.
    task automatic model(input logic [4:0] sel, input int a, input int b, input logic lsb,
                         output int res, output int cout);
        res  = 0;
        cout = 0;
        if (sel[4]) begin
            res  = (a + b) % 16;
            cout = (a + b) >= 16 ? 1 : 0;
        end else if (sel[3]) begin
            res  = (a - b + 16) % 16;
            cout = (a >= b) ? 1 : 0;
        end else if (sel[2]) begin
            if (lsb) begin
                res  = (a + b) % 16;
                cout = (a + b) >= 16 ? 1 : 0;
            end else begin
                res = a;
            end
        end else if (sel[1]) begin
            if (a >= b) begin
                res  = a - b;
                cout = 1;
            end else begin
                res = a;
            end
        end else if (sel[0]) begin
            res = a & b;
        end
    endtask

    task automatic xact(input logic [4:0] sel, input logic [3:0] a, input logic [3:0] b,
                        input logic lsb, input logic rst);
        int res;
        int cout;
        @(negedge clk);
        {alu_add, alu_sub, alu_mul, alu_div, alu_and} = sel;
        AH_in   = a;
        BREG_in = b;
        al_lsb  = lsb;
        clr     = rst;
        #1;
        model(sel, int'(a), int'(b), lsb, res, cout);
        check("alu_out", {4'b0, ALU_out}, 8'(res));
        check("fa_cout", {7'b0, Fa_cout}, 8'(cout));
        if (rst) begin
            m_sign  = 1'b0;
            m_carry = 1'b0;
            m_zero  = 1'b0;
        end else if (sel != 5'b0) begin
            m_sign  = (res >= 8);
            m_carry = (cout != 0);
            m_zero  = (res == 0);
        end
        @(posedge clk);
        #1;
        check("sign_flag",  {7'b0, sign_flag},  {7'b0, m_sign});
        check("carry_flag", {7'b0, carry_flag}, {7'b0, m_carry});
        check("zero_flag",  {7'b0, zero_flag},  {7'b0, m_zero});
        $display("xact sel=%05b clr=%0b A=%h B=%h lsb=%0b -> out=%h cout=%0b flags s/c/z=%0b%0b%0b",
                 sel, rst, a, b, lsb, ALU_out, Fa_cout, sign_flag, carry_flag, zero_flag);
    endtask

    initial begin
        assert_cnt = 0;
        fail_cnt   = 0;
        {alu_add, alu_sub, alu_mul, alu_div, alu_and} = 5'b0;
        AH_in = 4'h0; BREG_in = 4'h0; al_lsb = 1'b0; clr = 1'b0;
        m_sign = 1'b0; m_carry = 1'b0; m_zero = 1'b0;

        // Directed cases
        xact(5'b00000, 4'h0, 4'h0, 1'b0, 1'b1);   // reset, no selects
        xact(5'b10000, 4'hD, 4'h7, 1'b0, 1'b0);   // add with carry
        xact(5'b01000, 4'h5, 4'hA, 1'b0, 1'b0);   // sub with borrow
        xact(5'b01000, 4'h5, 4'h5, 1'b0, 1'b0);   // sub to zero
        xact(5'b00100, 4'h3, 4'h4, 1'b1, 1'b0);   // mul step, lsb=1
        xact(5'b00100, 4'h3, 4'h4, 1'b0, 1'b0);   // mul step, lsb=0
        xact(5'b00010, 4'h3, 4'h5, 1'b0, 1'b0);   // div restore
        xact(5'b00010, 4'h7, 4'h2, 1'b0, 1'b0);   // div subtract
        xact(5'b00000, 4'hF, 4'hF, 1'b1, 1'b0);   // flags hold
        xact(5'b00001, 4'hC, 4'hA, 1'b0, 1'b0);   // and
        xact(5'b11000, 4'h9, 4'h8, 1'b0, 1'b0);   // add beats sub
        xact(5'b10000, 4'hF, 4'h1, 1'b0, 1'b0);   // wrap to zero
        xact(5'b10000, 4'hF, 4'h1, 1'b0, 1'b1);   // clr beats add
        xact(5'b01111, 4'h2, 4'h6, 1'b1, 1'b0);   // sub beats the rest
        xact(5'b00111, 4'h6, 4'h6, 1'b0, 1'b0);   // mul lsb=0 beats div

        // Random operations
        for (int i = 0; i < 300; i++) begin
            xact(5'($urandom_range(0, 31)), 4'($urandom), 4'($urandom),
                 1'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
